tx_queue_arbiter: RTL and testbench

Schedules transmissions from four hardware TX queues (slices) onto the single transmit path once the CSMA/CA backoff grants access. Round-robin selection among queues that both have a frame pending and are allowed by the backoff engine. Maintains a per-queue contention-window exponent and retry counter with binary exponential backoff. Feeds the current CW exponent back to the backoff engine's `cw_min` input.

---
 rtl/tx_arb_pkg.sv | 28 ++
 rtl/tx_queue_arbiter_rr_pick4.sv | 29 ++
 rtl/tx_queue_arbiter.sv | 153 +++++++++++++++
 tb/tb_tx_queue_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and widths for the TX queue arbiter: FSM states, per-queue
// backoff context and the retry-limit helper.
package tx_arb_pkg;

    localparam int NUM_Q    = 4;
    localparam int QID_W    = 2;
    localparam int CW_EXP_W = 4;
    localparam int RETRY_W  = 4;
    localparam int TMO_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_UPDATE    = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [CW_EXP_W-1:0] cw;
        logic [RETRY_W-1:0]  retry;
    } q_ctx_t;

    // A programmed limit of zero still allows one attempt.
    function automatic logic [RETRY_W-1:0] eff_limit(input logic [RETRY_W-1:0] lim);
        return (lim == '0) ? RETRY_W'(1) : lim;
    endfunction

endpackage

// File: rtl/tx_queue_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set bit of vec at or after ptr,
// wrapping 3 -> 0.
module rr_pick4
    import tx_arb_pkg::*;
(
    input  logic [NUM_Q-1:0] vec,
    input  logic [QID_W-1:0] ptr,
    output logic             found,
    output logic [QID_W-1:0] idx
);

    logic [2*NUM_Q-1:0] dbl;
    logic [NUM_Q-1:0]   rot;

    always_comb begin
        dbl   = {vec, vec} >> ptr;
        rot   = dbl[NUM_Q-1:0];
        found = |vec;
        idx   = ptr;
        casez (rot)
            4'b???1: idx = ptr;
            4'b??10: idx = ptr + 2'd1;
            4'b?100: idx = ptr + 2'd2;
            4'b1000: idx = ptr + 2'd3;
            default: idx = ptr;
        endcase
    end

endmodule

// File: rtl/tx_queue_arbiter.sv
// Round-robin scheduler of four TX queues onto the single transmit path, with
// per-queue binary exponential backoff state and a tx_done watchdog.
module tx_queue_arbiter
    import tx_arb_pkg::*;
#(
    parameter int TX_TIMEOUT_US = 4095
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tsf_pulse_1M,
    input  logic [3:0] q_pending,
    input  logic [3:0] tx_allowed,
    input  logic [3:0] cw_min_exp,
    input  logic [3:0] cw_max_exp,
    input  logic [3:0] retry_limit,
    input  logic       tx_done,
    input  logic       tx_ack_ok,
    output logic       tx_start,
    output logic [1:0] tx_qid,
    output logic       busy,
    output logic [3:0] cw_exp_out,
    output logic       drop_strobe,
    output logic [1:0] drop_qid,
    output logic       timeout_err
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TX_TIMEOUT_US);

    arb_state_e              state, state_nxt;
    logic [QID_W-1:0]        rr_ptr;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    ok_q;
    q_ctx_t [NUM_Q-1:0]      ctx;
    q_ctx_t                  cur_ctx;
    logic [RETRY_W-1:0]      retry_n;
    logic                    drop_hit;
    logic                    release_q;

    logic [NUM_Q-1:0]        req;
    logic                    grant_found, cand_found;
    logic [QID_W-1:0]        grant_idx, cand_idx;

    assign req = q_pending & tx_allowed;

    rr_pick4 u_grant_pick (
        .vec   (req),
        .ptr   (rr_ptr),
        .found (grant_found),
        .idx   (grant_idx)
    );

    rr_pick4 u_cand_pick (
        .vec   (q_pending),
        .ptr   (rr_ptr),
        .found (cand_found),
        .idx   (cand_idx)
    );

    // Outcome of the attempt in flight; only consumed while in UPDATE.
    assign cur_ctx   = ctx[tx_qid];
    assign retry_n   = cur_ctx.retry + RETRY_W'(1);
    assign drop_hit  = !ok_q && (retry_n >= eff_limit(retry_limit));
    assign release_q = ok_q || drop_hit;

    assign busy     = (state != ST_IDLE);
    assign drop_qid = tx_qid;

    always_comb begin
        state_nxt   = state;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        drop_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_found) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = ST_UPDATE;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    timeout_err = rstn;
                    state_nxt   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                drop_strobe = drop_hit && rstn;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            tx_qid     <= '0;
            tmo_cnt    <= '0;
            ok_q       <= 1'b0;
            cw_exp_out <= '0;
        end else begin
            state      <= state_nxt;
            cw_exp_out <= cand_found ? ctx[cand_idx].cw : cw_min_exp;
            case (state)
                ST_IDLE: begin
                    if (grant_found) tx_qid <= grant_idx;
                end
                ST_GRANT: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (tx_done)
                        ok_q <= tx_ack_ok;
                    else if (tmo_cnt == TMO_LIMIT)
                        ok_q <= 1'b0;
                    else if (tsf_pulse_1M)
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                ST_UPDATE: begin
                    // A plain retry keeps the pointer so the same queue contends again.
                    if (release_q) rr_ptr <= tx_qid + QID_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        q_ctx_t ctx_r;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                ctx_r.cw    <= cw_min_exp;
                ctx_r.retry <= '0;
            end else if (state == ST_UPDATE && tx_qid == QID_W'(g)) begin
                if (release_q) begin
                    ctx_r.cw    <= cw_min_exp;
                    ctx_r.retry <= '0;
                end else begin
                    ctx_r.retry <= retry_n;
                    if (ctx_r.cw < cw_max_exp) ctx_r.cw <= ctx_r.cw + CW_EXP_W'(1);
                end
            end
        end

        assign ctx[g] = ctx_r;
    end

endmodule

// File: tb/tb_tx_queue_arbiter.sv
// Directed bench for tx_queue_arbiter: grant latency, round-robin order,
// exponential backoff, drop, timeout and mid-transmission reset.
module tb_tx_queue_arbiter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tsf_pulse_1M = 1'b0;
    logic [3:0] q_pending = 4'h0;
    logic [3:0] tx_allowed = 4'h0;
    logic [3:0] cw_min_exp = 4'd4;
    logic [3:0] cw_max_exp = 4'd6;
    logic [3:0] retry_limit = 4'd7;
    logic       tx_done = 1'b0;
    logic       tx_ack_ok = 1'b0;
    logic       tx_start, busy, drop_strobe, timeout_err;
    logic [1:0] tx_qid, drop_qid;
    logic [3:0] cw_exp_out;

    int checks = 0;
    int errors = 0;

    tx_queue_arbiter #(.TX_TIMEOUT_US(10)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tsf_pulse_1M (tsf_pulse_1M),
        .q_pending    (q_pending),
        .tx_allowed   (tx_allowed),
        .cw_min_exp   (cw_min_exp),
        .cw_max_exp   (cw_max_exp),
        .retry_limit  (retry_limit),
        .tx_done      (tx_done),
        .tx_ack_ok    (tx_ack_ok),
        .tx_start     (tx_start),
        .tx_qid       (tx_qid),
        .busy         (busy),
        .cw_exp_out   (cw_exp_out),
        .drop_strobe  (drop_strobe),
        .drop_qid     (drop_qid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; q_pending = 4'h0; tx_allowed = 4'h0;
        tx_done = 1'b0; tx_ack_ok = 1'b0; tsf_pulse_1M = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    // Returns in the cycle where tx_start is observed, or after 20 cycles.
    task automatic wait_start(output bit got, output int waited);
        got = 1'b0; waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); waited++;
            if (tx_start === 1'b1) got = 1'b1;
        end
    endtask

    // Called in the GRANT cycle; returns in the IDLE cycle after UPDATE.
    task automatic finish_tx(input logic ok, output logic drop, output logic [1:0] dq);
        tick();
        tx_done = 1'b1; tx_ack_ok = ok;
        tick();
        tx_done = 1'b0; tx_ack_ok = 1'b0;
        drop = drop_strobe; dq = drop_qid;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (drop_strobe !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop_strobe); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        checks++; if (tx_qid !== 2'd0) begin errors++; $display("FAIL reset_qid got %0d want 0", tx_qid); end
        checks++; if (cw_exp_out !== 4'd0) begin errors++; $display("FAIL reset_cw_out got %0d want 0", cw_exp_out); end
        rstn = 1'b1;
        tick(); tick();
        checks++; if (cw_exp_out !== 4'd4) begin errors++; $display("FAIL idle_cw_out got %0d want 4", cw_exp_out); end
    endtask

    task automatic test_single();
        bit got; int w; logic d; logic [1:0] dq;
        do_reset();
        q_pending = 4'b0001; tx_allowed = 4'b0001;
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_n1 got %b want 1", tx_start); end
        checks++; if (tx_qid !== 2'd0) begin errors++; $display("FAIL single_qid got %0d want 0", tx_qid); end
        checks++; if (cw_exp_out !== 4'd4) begin errors++; $display("FAIL single_cw got %0d want 4", cw_exp_out); end
        tx_done = 1'b1; tx_ack_ok = 1'b0;
        tick();
        tx_done = 1'b0;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b want 0", tx_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_stray_done_busy got %b want 1", busy); end
        tick(); tick(); tick();
        tx_done = 1'b1; tx_ack_ok = 1'b1; q_pending = 4'b0000;
        tick();
        tx_done = 1'b0; tx_ack_ok = 1'b0;
        checks++; if (busy !== 1'b1 || drop_strobe !== 1'b0) begin errors++; $display("FAIL single_update busy %b drop %b want 1 0", busy, drop_strobe); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
        q_pending = 4'b0001; tx_allowed = 4'b0000;
        tick(); tick();
        checks++; if (cw_exp_out !== 4'd4) begin errors++; $display("FAIL single_cw_after got %0d want 4", cw_exp_out); end
        q_pending = 4'b1111; tx_allowed = 4'b1111;
        wait_start(got, w);
        q_pending = 4'b0000; tx_allowed = 4'b0000;
        checks++; if (!got || tx_qid !== 2'd1) begin errors++; $display("FAIL single_rr_ptr got qid %0d start %b want 1", tx_qid, got); end
        finish_tx(1'b1, d, dq);
    endtask

    task automatic test_round_robin();
        bit got; int w; logic d; logic [1:0] dq;
        logic [1:0] exp_q [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        q_pending = 4'b1111; tx_allowed = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(got, w);
            if (i == 4) begin q_pending = 4'b0000; tx_allowed = 4'b0000; end
            checks++; if (!got || tx_qid !== exp_q[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, tx_qid, exp_q[i]); end
            checks++; if (w != 1) begin errors++; $display("FAIL rr_latency[%0d] got %0d cycles want 1", i, w); end
            finish_tx(1'b1, d, dq);
            checks++; if (d !== 1'b0) begin errors++; $display("FAIL rr_nodrop[%0d] got %b want 0", i, d); end
        end
    endtask

    task automatic test_backoff();
        bit got; int w; logic d; logic [1:0] dq;
        logic [3:0] exp_cw [7] = '{4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
        cw_min_exp = 4'd4; cw_max_exp = 4'd6; retry_limit = 4'd7;
        do_reset();
        q_pending = 4'b0100; tx_allowed = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            wait_start(got, w);
            checks++; if (!got || tx_qid !== 2'd2) begin errors++; $display("FAIL bo_qid[%0d] got %0d want 2", i, tx_qid); end
            checks++; if (cw_exp_out !== exp_cw[i]) begin errors++; $display("FAIL bo_cw[%0d] got %0d want %0d", i, cw_exp_out, exp_cw[i]); end
            if (i == 6) tx_allowed = 4'b0000;
            finish_tx(1'b0, d, dq);
            checks++; if (d !== (i == 6)) begin errors++; $display("FAIL bo_drop[%0d] got %b want %b", i, d, (i == 6)); end
            if (i == 6) begin
                checks++; if (dq !== 2'd2) begin errors++; $display("FAIL bo_drop_qid got %0d want 2", dq); end
            end
        end
        tick(); tick();
        checks++; if (cw_exp_out !== 4'd4) begin errors++; $display("FAIL bo_cw_reset got %0d want 4", cw_exp_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bo_idle got %b want 0", busy); end
    endtask

    task automatic test_retry_limit_zero();
        bit got; int w; logic d; logic [1:0] dq;
        retry_limit = 4'd0;
        do_reset();
        q_pending = 4'b0010; tx_allowed = 4'b0010;
        wait_start(got, w);
        tx_allowed = 4'b0000;
        checks++; if (!got || tx_qid !== 2'd1) begin errors++; $display("FAIL lim0_qid got %0d want 1", tx_qid); end
        finish_tx(1'b0, d, dq);
        checks++; if (d !== 1'b1 || dq !== 2'd1) begin errors++; $display("FAIL lim0_drop got %b qid %0d want 1 qid 1", d, dq); end
        tick(); tick();
        checks++; if (cw_exp_out !== 4'd4) begin errors++; $display("FAIL lim0_cw got %0d want 4", cw_exp_out); end
        retry_limit = 4'd7;
    endtask

    task automatic test_timeout();
        bit got; int w; logic d; logic [1:0] dq; bit early;
        retry_limit = 4'd2;
        do_reset();
        q_pending = 4'b0011; tx_allowed = 4'b0011;
        wait_start(got, w);
        checks++; if (!got || tx_qid !== 2'd0) begin errors++; $display("FAIL tmo_qid got %0d want 0", tx_qid); end
        tick();
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tsf_pulse_1M = 1'b1;
            tick();
            tsf_pulse_1M = 1'b0;
            if (i < 9) begin
                if (timeout_err !== 1'b0 || busy !== 1'b1) early = 1'b1;
                tick();
            end
        end
        checks++; if (early) begin errors++; $display("FAIL tmo_early got early timeout want none before tick 10"); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b0 || drop_strobe !== 1'b0) begin errors++; $display("FAIL tmo_update err %b drop %b want 0 0", timeout_err, drop_strobe); end
        tick();
        wait_start(got, w);
        tx_allowed = 4'b0000;
        checks++; if (!got || tx_qid !== 2'd0 || w != 1) begin errors++; $display("FAIL tmo_retry_same_q got %0d after %0d want 0 after 1", tx_qid, w); end
        checks++; if (cw_exp_out !== 4'd5) begin errors++; $display("FAIL tmo_cw got %0d want 5", cw_exp_out); end
        finish_tx(1'b0, d, dq);
        checks++; if (d !== 1'b1 || dq !== 2'd0) begin errors++; $display("FAIL tmo_second_drop got %b qid %0d want 1 qid 0", d, dq); end
        tx_done = 1'b1; tx_ack_ok = 1'b1;
        tick();
        tx_done = 1'b0; tx_ack_ok = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || drop_strobe !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL tmo_stray_done busy %b drop %b start %b want 0 0 0", busy, drop_strobe, tx_start); end
        tx_allowed = 4'b0011;
        wait_start(got, w);
        q_pending = 4'b0000; tx_allowed = 4'b0000;
        checks++; if (!got || tx_qid !== 2'd1 || cw_exp_out !== 4'd4) begin errors++; $display("FAIL tmo_next_q got %0d cw %0d want 1 cw 4", tx_qid, cw_exp_out); end
        finish_tx(1'b1, d, dq);
        retry_limit = 4'd7;
    endtask

    task automatic test_reset_mid();
        bit got; int w; logic d; logic [1:0] dq;
        do_reset();
        q_pending = 4'b1111; tx_allowed = 4'b1111;
        wait_start(got, w);
        finish_tx(1'b1, d, dq);
        wait_start(got, w);
        checks++; if (!got || tx_qid !== 2'd1) begin errors++; $display("FAIL rmid_second_q got %0d want 1", tx_qid); end
        tick(); tick();
        rstn = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0 || drop_strobe !== 1'b0) begin errors++; $display("FAIL rmid_outputs start %b busy %b drop %b want 0 0 0", tx_start, busy, drop_strobe); end
        checks++; if (tx_qid !== 2'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_qid got %0d tmo %b want 0 0", tx_qid, timeout_err); end
        rstn = 1'b1;
        wait_start(got, w);
        q_pending = 4'b0000; tx_allowed = 4'b0000;
        checks++; if (!got || tx_qid !== 2'd0 || w != 1) begin errors++; $display("FAIL rmid_regrant got %0d after %0d want 0 after 1", tx_qid, w); end
        finish_tx(1'b1, d, dq);
        checks++; if (d !== 1'b0) begin errors++; $display("FAIL rmid_nodrop got %b want 0", d); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backoff();
        test_retry_limit_zero();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
